// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache miss/refill controller.
// Optional feature macro: DCACHE_PERF_CNT_EN (hit/miss performance counters).
package dcache_pkg;

    localparam int DCACHE_ADDR_W = 32;
    localparam int DCACHE_DATA_W = 32;
    localparam int PERF_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_FILL    = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_WAIT = 3'd5
    } dcache_state_e;

    // Request captured when the controller leaves IDLE for a memory operation.
    typedef struct packed {
        logic                     we;
        logic [DCACHE_ADDR_W-1:0] addr;
        logic [DCACHE_DATA_W-1:0] wdata;
    } dcache_req_t;

endpackage

// File: rtl/dcache_perf_cnt.sv
// Saturating hit/miss counters for the data-cache controller.
// Only instantiated when DCACHE_PERF_CNT_EN is defined.
module dcache_perf_cnt
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hit,
    input  logic              i_miss,
    output logic [PERF_W-1:0] o_hits,
    output logic [PERF_W-1:0] o_misses
);

    logic [PERF_W-1:0] r_hits;
    logic [PERF_W-1:0] r_misses;

    // Count accepted hits and misses, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (i_hit && (r_hits != '1)) begin
                r_hits <= r_hits + 1'b1;
            end
            if (i_miss && (r_misses != '1)) begin
                r_misses <= r_misses + 1'b1;
            end
        end
    end

    assign o_hits   = r_hits;
    assign o_misses = r_misses;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Miss/refill controller for a direct-mapped, word-per-line data cache.
// Write-through, no-write-allocate, one outstanding memory request.
// Optional feature macro: DCACHE_PERF_CNT_EN enables the perf_hits/perf_misses
// counters; when undefined both ports read 0 and no counter flops exist.
// The latched request struct is sized by the package defaults, so ADDR_W and
// DATA_W should only be overridden together with the package constants.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DCACHE_ADDR_W,
    parameter int DATA_W = DCACHE_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // Load/store unit side
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    // Cache array side
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_wr_en,
    output logic              cache_fill_en,
    output logic [DATA_W-1:0] cache_wdata,
    // Memory side
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    // Performance counters
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);

    dcache_state_e     r_state;
    dcache_req_t       r_req;
    logic [DATA_W-1:0] r_fill_data;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;

    logic w_idle;
    logic w_fill;
    logic w_accept;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_fill   = (r_state == ST_FILL);
    assign w_accept = cpu_req_valid && w_idle;

    // Request sequencing: hits finish in IDLE, misses and stores walk the memory states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_fill_data  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            // Response register is a one-cycle pulse; data is zero unless a load hit returns.
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (cpu_req_we) begin
                            // Store always goes to memory; the array write (on hit) is combinational.
                            r_req.we    <= 1'b1;
                            r_req.addr  <= cpu_req_addr;
                            r_req.wdata <= cpu_req_wdata;
                            r_state     <= ST_WR_REQ;
                        end else if (cache_hit) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= cache_rdata;
                        end else begin
                            r_req.we    <= 1'b0;
                            r_req.addr  <= cpu_req_addr;
                            r_req.wdata <= '0;
                            r_state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_resp_valid) begin
                        r_fill_data <= mem_resp_rdata;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_state <= ST_IDLE;
                end
                ST_WR_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Requester handshake and response; the fill cycle returns the refilled word directly.
    assign cpu_req_ready  = w_idle;
    assign cpu_resp_valid = r_resp_valid || w_fill;
    assign cpu_resp_rdata = w_fill ? r_fill_data : r_resp_rdata;

    // Cache array: look up the live request in IDLE, the latched one otherwise.
    assign cache_addr    = w_idle ? cpu_req_addr : r_req.addr;
    assign cache_wr_en   = w_accept && cpu_req_we && cache_hit;
    assign cache_fill_en = w_fill;
    assign cache_wdata   = cache_wr_en ? cpu_req_wdata :
                           (w_fill ? r_fill_data : '0);

    // Memory bus: fields come from the latched request, so they hold while ready is low.
    assign mem_req_valid = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign mem_req_we    = (r_state == ST_WR_REQ);
    assign mem_req_addr  = mem_req_valid ? r_req.addr : '0;
    assign mem_req_wdata = mem_req_we ? r_req.wdata : '0;

`ifdef DCACHE_PERF_CNT_EN
    logic w_perf_hit;
    logic w_perf_miss;

    assign w_perf_hit  = w_accept && cache_hit;
    assign w_perf_miss = w_accept && !cache_hit;

    dcache_perf_cnt u_perf_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hit    (w_perf_hit),
        .i_miss   (w_perf_miss),
        .o_hits   (perf_hits),
        .o_misses (perf_misses)
    );
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed testbench for dcache_miss_ctrl with a response scoreboard.
// Includes a behavioural direct-mapped cache array (256 word lines).
// Perf counter expectations follow DCACHE_PERF_CNT_EN.
module tb_dcache_miss_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_req_valid;
    logic          cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_req_ready;
    logic          cpu_resp_valid;
    logic [DW-1:0] cpu_resp_rdata;
    logic [AW-1:0] cache_addr;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic          cache_wr_en;
    logic          cache_fill_en;
    logic [DW-1:0] cache_wdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;
    logic [31:0]   perf_hits;
    logic [31:0]   perf_misses;

    dcache_miss_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cache_addr     (cache_addr),
        .cache_hit      (cache_hit),
        .cache_rdata    (cache_rdata),
        .cache_wr_en    (cache_wr_en),
        .cache_fill_en  (cache_fill_en),
        .cache_wdata    (cache_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural cache array ----------------
    logic [31:0] m_data  [256];
    logic [21:0] m_tag   [256];
    logic        m_valid [256];
    logic        model_init;

    always_comb begin
        cache_hit   = m_valid[cache_addr[9:2]] && (m_tag[cache_addr[9:2]] == cache_addr[31:10]);
        cache_rdata = m_data[cache_addr[9:2]];
    end

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 256; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= '0;
                m_data[i]  <= '0;
            end
            m_valid[16] <= 1'b1;
            m_data[16]  <= 32'hDEAD_BEEF;
        end else if (cache_fill_en) begin
            m_valid[cache_addr[9:2]] <= 1'b1;
            m_tag[cache_addr[9:2]]   <= cache_addr[31:10];
            m_data[cache_addr[9:2]]  <= cache_wdata;
        end else if (cache_wr_en) begin
            m_data[cache_addr[9:2]]  <= cache_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic push_resp(input logic [31:0] data, input int at_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = at_cyc;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_resp_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata %h at cycle %0d, expected no response", cpu_resp_rdata, cyc);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] resp cycle %0d rdata %h (expect %h at cycle %0d)", cyc, cpu_resp_rdata, e.data, e.cyc);
                chk("resp_rdata", cpu_resp_rdata, e.data);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    int exp_h = 0;
    int exp_m = 0;

    initial begin
        rst_n          = 1'b0;
        model_init     = 1'b1;
        cpu_req_valid  = 1'b0;
        cpu_req_we     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_wdata  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;

        // ---------------- reset values ----------------
        repeat (3) tick;
        model_init = 1'b0;
        neg;
        chk("rst_ready", cpu_req_ready, 1);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_wr_en", cache_wr_en, 0);
        chk("rst_fill_en", cache_fill_en, 0);
        chk("rst_perf_hits", perf_hits, 0);
        chk("rst_perf_misses", perf_misses, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // ---------------- load hits, back to back ----------------
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h40;
        push_resp(32'hDEAD_BEEF, cyc + 1);
        neg;
        chk("hit_ready", cpu_req_ready, 1);
        tick;
        push_resp(32'hDEAD_BEEF, cyc + 1);
        neg;
        chk("hit_no_mem_req", mem_req_valid, 0);
        tick;
        cpu_req_valid = 1'b0;
        neg;
        chk("hit_no_mem_req2", mem_req_valid, 0);
        tick;

        // ---------------- load miss with stalled memory ----------------
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h1000;
        neg;
        tick;
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        for (int k = 0; k < 3; k++) begin
            neg;
            chk("miss_stall_valid", mem_req_valid, 1);
            chk("miss_stall_we", mem_req_we, 0);
            chk("miss_stall_addr", mem_req_addr, 32'h1000);
            chk("miss_stall_not_ready", cpu_req_ready, 0);
            tick;
        end
        mem_req_ready = 1'b1;
        neg;
        chk("miss_req_addr", mem_req_addr, 32'h1000);
        tick;
        mem_req_ready = 1'b0;
        neg;
        chk("miss_wait_no_req", mem_req_valid, 0);
        tick;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
        push_resp(32'h1234_5678, cyc + 1);
        neg;
        tick;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        neg;
        chk("fill_en", cache_fill_en, 1);
        chk("fill_wdata", cache_wdata, 32'h1234_5678);
        chk("fill_resp_same_cycle", cpu_resp_valid, 1);
        tick;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h1000;
        push_resp(32'h1234_5678, cyc + 1);
        neg;
        tick;
        cpu_req_valid = 1'b0;
        neg;
        chk("refill_hit_no_mem", mem_req_valid, 0);
        tick;

        // ---------------- store hit ----------------
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h40; cpu_req_wdata = 32'hA5A5_A5A5;
        neg;
        chk("st_hit_wr_en", cache_wr_en, 1);
        chk("st_hit_wdata", cache_wdata, 32'hA5A5_A5A5);
        tick;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_wdata = '0;
        mem_req_ready = 1'b1;
        neg;
        chk("st_mem_valid", mem_req_valid, 1);
        chk("st_mem_we", mem_req_we, 1);
        chk("st_mem_addr", mem_req_addr, 32'h40);
        chk("st_mem_wdata", mem_req_wdata, 32'hA5A5_A5A5);
        chk("st_wr_en_once", cache_wr_en, 0);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        push_resp(32'h0, cyc + 1);
        neg;
        tick;
        mem_resp_valid = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h40;
        push_resp(32'hA5A5_A5A5, cyc + 1);
        neg;
        chk("st_ready_with_resp", cpu_req_ready, 1);
        tick;
        cpu_req_valid = 1'b0;
        neg;
        tick;

        // ---------------- store miss ----------------
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h2000; cpu_req_wdata = 32'h5555_0000;
        neg;
        chk("st_miss_no_wr_en", cache_wr_en, 0);
        tick;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_wdata = '0;
        mem_req_ready = 1'b1;
        neg;
        chk("st_miss_mem_addr", mem_req_addr, 32'h2000);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        push_resp(32'h0, cyc + 1);
        neg;
        tick;
        mem_resp_valid = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h2000;
        neg;
        tick;
        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        neg;
        chk("st_miss_load_misses", mem_req_valid, 1);
        chk("st_miss_load_we", mem_req_we, 0);
        chk("st_miss_load_addr", mem_req_addr, 32'h2000);
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
        push_resp(32'hCAFE_F00D, cyc + 1);
        neg;
        tick;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        neg;
        tick;

        // ---------------- reset during RD_WAIT ----------------
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h3000;
        neg;
        tick;
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        mem_req_ready = 1'b1;
        neg;
        tick;
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        neg;
        tick;
        rst_n = 1'b1;
        neg;
        chk("mid_rst_ready", cpu_req_ready, 1);
        chk("mid_rst_resp_valid", cpu_resp_valid, 0);
        chk("mid_rst_rdata", cpu_resp_rdata, 0);
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        chk("mid_rst_mem_addr", mem_req_addr, 0);
        chk("mid_rst_fill", cache_fill_en, 0);
        chk("mid_rst_cache_addr", cache_addr, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_0BAD;
        tick;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            neg;
            chk("stray_no_resp", cpu_resp_valid, 0);
            chk("stray_no_fill", cache_fill_en, 0);
            tick;
        end

        // ---------------- perf counters: 2 hits, 1 miss ----------------
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h40;
        push_resp(32'hA5A5_A5A5, cyc + 1);
        exp_h++;
        neg;
        tick;
        cpu_req_addr = 32'h2000;
        push_resp(32'hCAFE_F00D, cyc + 1);
        exp_h++;
        neg;
        tick;
        cpu_req_addr = 32'h4000;
        exp_m++;
        neg;
        tick;
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        mem_req_ready = 1'b1;
        neg;
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0077;
        push_resp(32'h0000_0077, cyc + 1);
        neg;
        tick;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        neg;
        tick;
        neg;
`ifdef DCACHE_PERF_CNT_EN
        chk("perf_hits", perf_hits, exp_h);
        chk("perf_misses", perf_misses, exp_m);
`else
        chk("perf_hits_off", perf_hits, 0);
        chk("perf_misses_off", perf_misses, 0);
`endif
        tick;

        // ---------------- drain scoreboard (bounded) ----------------
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick;
        chk("sb_pending", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
